// File: rtl/ram_dump_tx.sv
// ram_dump_tx
//
// Purpose:
//   Walks an inclusive, wrapping range of addresses in a 64x8 asynchronous-read
//   RAM and sends each byte as an 8N1 frame (start bit, 8 data bits LSB first,
//   stop bit) on a serial line. Bytes go out back to back. The only gap between
//   frames is the one LOAD cycle that fetches the next byte.
//
// Parameters:
//   BAUD_DIV    clk_out cycles per serial bit (2..65535)
//
// Ports:
//   clk_out     clock; all state changes on its rising edge
//   rst         synchronous, active-low reset; overrides start and abort
//   start       one-cycle request to begin a dump; ignored while busy
//   abort       cancels the dump in progress; the next state is IDLE
//   first_addr  first RAM address to send (latched when start is accepted)
//   last_addr   final RAM address to send (latched when start is accepted)
//   rd_addr     RAM read address; always the current address register
//   rd_data     RAM read data for rd_addr, valid in the same cycle
//   tx          serial output, idle high (registered)
//   busy        high whenever the FSM is not IDLE (registered)
//   done        one-cycle pulse when the final byte's stop bit completes
//
// Timing notes:
//   tx is registered from the current state, so it trails the state by one
//   cycle. The frame therefore starts on the second edge after the edge that
//   samples start. The stop bit of one byte and the LOAD cycle of the next
//   together keep the line high. busy is registered from the next state, so it
//   matches the state exactly. This makes a byte slot 10*BAUD_DIV+1 cycles long.
`timescale 1ns/1ps
module ram_dump_tx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] first_addr,
    input  logic [5:0] last_addr,
    output logic [5:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      state_reg, state_next;
    logic [15:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [5:0]  cur_reg, cur_next;
    logic [5:0]  end_addr_reg, end_addr_next;
    logic [7:0]  shift_reg, shift_next;
    logic        tx_reg, tx_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        baud_end;
    logic        last_byte;

    assign baud_end  = (baud_cnt_reg == BAUD_LAST);
    assign last_byte = (cur_reg == end_addr_reg);

    assign rd_addr = cur_reg;
    assign tx      = tx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

    // ------------------------------------------------------------------
    // State register (and all datapath/output registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            cur_reg      <= '0;
            end_addr_reg <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            cur_reg      <= cur_next;
            end_addr_reg <= end_addr_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        end_addr_next = end_addr_reg;
        shift_next    = shift_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next    = LOAD;
                    cur_next      = first_addr;
                    end_addr_next = last_addr;
                end
            end
            LOAD: begin
                state_next = START;
                shift_next = rd_data;
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (last_byte) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                        // 6-bit add wraps 63 -> 0 on its own.
                        cur_next   = cur_reg + 6'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort cancels everything, including a pending address advance.
        if (abort) begin
            state_next = IDLE;
            cur_next   = cur_reg;
            if (state_reg == IDLE) begin
                end_addr_next = end_addr_reg;
            end
        end

        // Counters restart on every state entry. The baud counter wraps at
        // each bit boundary, and the bit counter only advances in DATA.
        if (state_next != state_reg) begin
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
        end else begin
            baud_cnt_next = baud_end ? 16'd0 : baud_cnt_reg + 16'd1;
            bit_cnt_next  = bit_cnt_reg;
            if (state_reg == DATA && baud_end) begin
                bit_cnt_next = bit_cnt_reg + 3'd1;
            end
            if (state_reg == IDLE) begin
                baud_cnt_next = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered through tx/busy/done _reg)
    // ------------------------------------------------------------------
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        done_next = 1'b0;

        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
            STOP:    done_next = baud_end && last_byte;
            default: tx_next = 1'b1;
        endcase

        if (abort) begin
            tx_next   = 1'b1;
            done_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Testbench for ram_dump_tx with BAUD_DIV=4 and a RAM preloaded with
// mem[i] = i ^ 8'hA5. The reference model treats each dump as a list of byte
// slots. Each slot is 41 cycles long. Within a slot, the expected tx, busy,
// done and rd_addr values are derived from the slot index and the offset.
`timescale 1ns/1ps
module tb_ram_dump_tx;

    localparam int BD   = 4;
    localparam int SLOT = 10 * BD + 1;

    logic       clk_out;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] first_addr;
    logic [5:0] last_addr;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:63];

    int checks;
    int errors;
    int last_rd;

    ram_dump_tx #(.BAUD_DIV(BD)) dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    assign rd_data = mem[rd_addr];

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k, input int addr);
        chk({tag, "_tx"},   k, 32'(tx),      1);
        chk({tag, "_busy"}, k, 32'(busy),    0);
        chk({tag, "_done"}, k, 32'(done),    0);
        chk({tag, "_addr"}, k, 32'(rd_addr), addr);
    endtask

    // Run one dump from f to l. abort_k, spur_k and rst_k give the edge index
    // (relative to the edge that samples start) at which abort, a spurious
    // start, or reset is applied. Use -1 to disable each one.
    task automatic run_dump(input int f, input int l, input int abort_k,
                            input int spur_k, input int rst_k);
        int n, k, stop_k, j, o, idx;
        int addr_q[$];
        int exp_tx, exp_busy, exp_done, exp_addr;
        logic [7:0] b, sh;

        n = ((l - f + 64) % 64) + 1;
        for (int i = 0; i < n; i++) addr_q.push_back((f + i) % 64);
        stop_k = SLOT * n + 3;

        @(negedge clk_out);
        first_addr = 6'(f);
        last_addr  = 6'(l);
        start      = 1'b1;
        @(posedge clk_out);
        @(negedge clk_out);
        start      = 1'b0;
        // Changes after latching must not matter.
        first_addr = 6'($urandom);
        last_addr  = 6'($urandom);

        k = 0;
        while (k <= stop_k) begin
            if (rst_k >= 0 && k >= rst_k) begin
                exp_tx = 1; exp_busy = 0; exp_done = 0; exp_addr = 0;
            end else if (abort_k >= 0 && k >= abort_k) begin
                idx = (abort_k - 1) / SLOT;
                if (idx > n - 1) idx = n - 1;
                exp_tx = 1; exp_busy = 0; exp_done = 0; exp_addr = addr_q[idx];
            end else begin
                exp_busy = (k < SLOT * n) ? 1 : 0;
                exp_done = (k == SLOT * n) ? 1 : 0;
                idx = k / SLOT;
                if (idx > n - 1) idx = n - 1;
                exp_addr = addr_q[idx];
                exp_tx = 1;
                if (k >= 1 && k <= SLOT * n) begin
                    j = (k - 1) / SLOT;
                    o = k - SLOT * j;
                    b = mem[addr_q[j]];
                    if (o >= 2 && o <= 1 + BD) begin
                        exp_tx = 0;
                    end else if (o >= 2 + BD && o <= 1 + 9 * BD) begin
                        sh = b >> ((o - 2 - BD) / BD);
                        exp_tx = 32'(sh[0]);
                    end
                end
            end
            chk("tx",      k, 32'(tx),      exp_tx);
            chk("busy",    k, 32'(busy),    exp_busy);
            chk("done",    k, 32'(done),    exp_done);
            chk("rd_addr", k, 32'(rd_addr), exp_addr);

            abort = (k + 1 == abort_k);
            rst   = !(k + 1 == rst_k);
            start = (k + 1 == spur_k) || (k + 1 == rst_k);
            if (k + 1 == abort_k || k + 1 == rst_k) stop_k = k + 4;
            @(posedge clk_out);
            @(negedge clk_out);
            k++;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        last_rd = exp_addr;
        $display("dump first=%0d last=%0d bytes=%0d abort_at=%0d spur_at=%0d rst_at=%0d checks=%0d errors=%0d",
                 f, l, n, abort_k, spur_k, rst_k, checks, errors);
    endtask

    initial begin
        int f, l, n, ak;
        checks  = 0;
        errors  = 0;
        last_rd = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;

        // Reset, with start held high to show reset has priority.
        rst = 1'b0; start = 1'b1; abort = 1'b0;
        first_addr = 6'd9; last_addr = 6'd12;
        repeat (3) @(posedge clk_out);
        @(negedge clk_out);
        chk_idle("reset", 0, 0);
        rst = 1'b1; start = 1'b0;
        repeat (2) begin
            @(negedge clk_out);
            chk_idle("post_reset", 0, 0);
        end
        $display("reset sequence checks=%0d errors=%0d", checks, errors);

        run_dump(5, 5, -1, -1, -1);     // single byte 0xA0
        run_dump(2, 4, -1, -1, -1);     // 0xA7 0xA6 0xA1
        run_dump(62, 1, -1, -1, -1);    // wrap 62,63,0,1
        run_dump(7, 9, 19, -1, -1);     // abort during DATA bit 3
        run_dump(7, 7, -1, -1, -1);     // normal after abort

        // abort and start together in IDLE: abort wins.
        @(negedge clk_out);
        start = 1'b1; abort = 1'b1; first_addr = 6'd30; last_addr = 6'd31;
        @(posedge clk_out);
        @(negedge clk_out);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_idle("abort_start_idle", i, last_rd);
            @(negedge clk_out);
        end
        $display("idle abort+start checks=%0d errors=%0d", checks, errors);

        run_dump(10, 14, -1, 50, 80);   // spurious start, then reset in STOP of byte 2
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_out);
            chk_idle("after_rst", i, 0);
        end
        run_dump(0, 63, -1, -1, -1);    // full 64 bytes

        repeat (4) begin
            f  = int'($urandom_range(0, 63));
            l  = (f + int'($urandom_range(0, 4))) % 64;
            n  = ((l - f + 64) % 64) + 1;
            ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SLOT * n)) : -1;
            run_dump(f, l, ak, int'($urandom_range(2, SLOT * n - 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dump_tx.md
RAM_DUMP_TX -- requirements
Module: ram_dump_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 16, meaning clk_out cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port clk_out, input, 1 bit, the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a single-cycle debounced pulse requesting a dump.
REQ-005 The block SHALL have port abort, input, 1 bit, a synchronous request to cancel the dump in progress.
REQ-006 The block SHALL have port first_addr, input, 6 bits, the first RAM address to send.
REQ-007 The block SHALL have port last_addr, input, 6 bits, the final RAM address to send.
REQ-008 The block SHALL have port rd_addr, output, 6 bits, the read address driven to the 64x8 RAM.
REQ-009 The block SHALL have port rd_data, input, 8 bits, the asynchronous RAM read data for rd_addr, valid in the same cycle.
REQ-010 The block SHALL have port tx, output, 1 bit, the 8N1 serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking completion of a full dump.

Function
REQ-013 The block SHALL implement the states IDLE, LOAD, START, DATA and STOP; tx, busy and done SHALL all be registered.
REQ-014 In IDLE, a start=1 sample SHALL latch cur=first_addr and end=last_addr, then enter LOAD.
REQ-015 In LOAD (exactly 1 cycle), rd_addr SHALL equal cur, and rd_data SHALL be captured into an 8-bit shift register at the closing edge; the next state is START.
REQ-016 START SHALL drive tx=0 for BAUD_DIV cycles.
REQ-017 DATA SHALL drive 8 bits LSB first, BAUD_DIV cycles each.
REQ-018 STOP SHALL drive tx=1 for BAUD_DIV cycles.
REQ-019 A byte slot SHALL last exactly 10*BAUD_DIV+1 cycles, LOAD included.
REQ-020 The first tx falling edge SHALL appear 2 edges after the edge that sampled start.
REQ-021 At the end of STOP with cur!=end, the block SHALL set cur=(cur+1) mod 64 and enter LOAD, with no idle gap beyond the LOAD cycle.
REQ-022 At the end of STOP with cur==end, the block SHALL enter IDLE with done=1 for exactly that one cycle and busy=0 in that same cycle.
REQ-023 When last_addr<first_addr, addresses SHALL wrap from 63 to 0 and continue until end is sent; first_addr==last_addr SHALL send exactly 1 byte; first=0, last=63 SHALL send 64 bytes.
REQ-024 start while busy=1 SHALL be ignored; first_addr and last_addr changes after latching SHALL have no effect.
REQ-025 abort=1 in any state other than IDLE SHALL force IDLE at the next edge: tx=1, busy=0, done=0, with the partial byte truncated.
REQ-026 When abort and start are both high in IDLE, abort SHALL win and the block SHALL remain in IDLE.
REQ-027 rd_addr SHALL equal cur at all times; in IDLE it SHALL hold the last used address (0 after reset).
REQ-028 The baud counter and bit counter SHALL reset to 0 on every state entry.

Reset
REQ-029 On rst=0 at a clock edge, the block SHALL go to IDLE with tx=1, busy=0, done=0, rd_addr=0 and all counters and the shift register at 0.
REQ-030 A reset in mid-frame SHALL take effect at that edge (tx=1 the following cycle) and SHALL have priority over start and abort.
REQ-031 The block SHALL not start a dump until start is sampled after rst returns high.

Verification (BAUD_DIV=4, RAM model preloaded mem[i]=i^8'hA5)
REQ-032 Single byte: first=last=5, start pulse -> tx frame 0,(0xA0 LSB first: 0,0,0,0,0,1,0,1),1, each bit 4 cycles; done pulses 41 cycles after the start edge; busy high for 41 cycles.
REQ-033 Range: first=2, last=4 -> bytes 0xA7, 0xA6, 0xA1 back to back, 123 busy cycles, one done pulse, rd_addr sequence 2,3,4.
REQ-034 Wrap: first=62, last=1 -> 4 bytes from addresses 62,63,0,1, i.e. 0x9B, 0x9A, 0xA5, 0xA4.
REQ-035 Abort: assert abort during DATA bit 3 of the first byte -> tx=1 the next cycle, busy=0, no done; a following start behaves normally.
REQ-036 Reset mid-dump: rst=0 during STOP of the second byte -> all outputs at reset values the next cycle; a start pulse while busy (before the reset) is ignored and the byte count is unchanged.
